image_ram_loader: RTL and testbench

- Writer side of the coprocessor image RAM (ccpu_ram write port).
- Accepts a pixel stream over a valid/ready handshake and writes IMG_W*IMG_H pixels sequentially from a latched base address.
- After the last write commits, emits the one-cycle start pulse consumed by the edge-detection coprocessor's clk_start input.

---
 rtl/coproc_pkg.sv | 16 +
 rtl/image_ram_loader_if.sv | 26 ++
 rtl/loader_addr_gen.sv | 43 ++++
 rtl/image_ram_loader.sv | 128 ++++++++++++
 tb/tb_image_ram_loader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: default geometry and loader state encoding.
package coproc_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned IMG_W_DEF  = 64;
  localparam int unsigned IMG_H_DEF  = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_COMMIT = 2'b10,
    ST_START  = 2'b11
  } loader_state_e;

endpackage

// File: rtl/image_ram_loader_if.sv
// Pixel-stream handshake plus RAM write port seen by the image loader.
interface image_ram_loader_if
  import coproc_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [ADDR_W-1:0] ram_wraddress;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;

  modport slave (
    input  pix_data, pix_valid,
    output pix_ready, ram_wraddress, ram_data, ram_wren
  );

  modport master (
    output pix_data, pix_valid,
    input  pix_ready, ram_wraddress, ram_data, ram_wren
  );

endinterface

// File: rtl/loader_addr_gen.sv
// Base latch, pixel counter, write address (mod 2^ADDR_W), wrap and last-pixel detect.
module loader_addr_gen
  import coproc_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              beat_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wrap_o,
  output logic              last_o
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(IMG_W * IMG_H - 1);

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W+1:0] sum_w;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q  <= '0;
      count_q <= '0;
    end else if (load_i) begin
      base_q  <= base_i;
      count_q <= '0;
    end else if (beat_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Two guard bits: any carry out of the low ADDR_W bits means the address wrapped.
  assign sum_w  = {2'b00, base_q} + {1'b0, count_q};
  assign addr_o = sum_w[ADDR_W-1:0];
  assign wrap_o = |sum_w[ADDR_W+1:ADDR_W];
  assign last_o = (count_q == LAST_CNT);

endmodule

// File: rtl/image_ram_loader.sv
// Image RAM writer: streams IMG_W*IMG_H pixels to RAM, then pulses clk_start.
// Optional LOADER_CHECKSUM_EN adds a 16-bit running sum of accepted pixels.
module image_ram_loader
  import coproc_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] base_addr,
  image_ram_loader_if.slave bus,
  output logic              clk_start,
  output logic              busy,
  output logic              wrap_flag
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  loader_state_e     state_q;
  logic              pix_ready_q;
  logic              ram_wren_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              clk_start_q;
  logic              busy_q;
  logic              wrap_q;

  logic              accept;
  logic              beat;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_wrap;
  logic              gen_last;

  assign accept = (state_q == ST_IDLE) && load_req;
  assign beat   = bus.pix_valid && pix_ready_q;

  loader_addr_gen #(
    .ADDR_W (ADDR_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) u_addr_gen (
    .clk_i  (clk_50M),
    .rst_i  (reset),
    .load_i (accept),
    .beat_i (beat),
    .base_i (base_addr),
    .addr_o (gen_addr),
    .wrap_o (gen_wrap),
    .last_o (gen_last)
  );

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pix_ready_q <= 1'b0;
      ram_wren_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      clk_start_q <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      ram_wren_q  <= 1'b0;
      clk_start_q <= 1'b0;
      if (beat) begin
        ram_wren_q <= 1'b1;
        ram_addr_q <= gen_addr;
        ram_data_q <= bus.pix_data;
        if (gen_wrap) wrap_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (load_req) begin
            state_q     <= ST_LOAD;
            pix_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            wrap_q      <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (beat && gen_last) begin
            state_q     <= ST_COMMIT;
            pix_ready_q <= 1'b0;
          end
        end
        ST_COMMIT: begin
          state_q     <= ST_START;
          clk_start_q <= 1'b1;
        end
        ST_START: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= '0;
    end else if (beat) begin
      checksum_q <= checksum_q + 16'(bus.pix_data);
    end
  end

  assign checksum = checksum_q;
`endif

  assign bus.pix_ready     = pix_ready_q;
  assign bus.ram_wren      = ram_wren_q;
  assign bus.ram_wraddress = ram_addr_q;
  assign bus.ram_data      = ram_data_q;
  assign clk_start         = clk_start_q;
  assign busy              = busy_q;
  assign wrap_flag         = wrap_q;

endmodule

// File: tb/tb_image_ram_loader.sv
// Scoreboard bench for image_ram_loader (4x4 image): driver pushes model writes/starts, monitor pops.
module tb_image_ram_loader;

  localparam int NPIX = 16;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        wrap;
  } wr_t;

  typedef struct {
    int          edge_no;
    bit          cont;
    logic        wrap;
    logic [15:0] sum;
  } start_t;

  logic        clk;
  logic        reset;
  logic        load_req;
  logic [11:0] base_addr;
  logic        clk_start;
  logic        busy;
  logic        wrap_flag;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit post_start = 0;

  wr_t    exp_w[$];
  start_t start_q[$];

  image_ram_loader_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  image_ram_loader #(
    .ADDR_W (12),
    .DATA_W (8),
    .IMG_W  (4),
    .IMG_H  (4)
  ) dut (
    .clk_50M   (clk),
    .reset     (reset),
    .load_req  (load_req),
    .base_addr (base_addr),
    .bus       (bus),
    .clk_start (clk_start),
    .busy      (busy),
    .wrap_flag (wrap_flag)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_ready"}, 32'(bus.pix_ready), 0);
    chk({tag, "_ram_wren"}, 32'(bus.ram_wren), 0);
    chk({tag, "_ram_wraddress"}, 32'(bus.ram_wraddress), 0);
    chk({tag, "_ram_data"}, 32'(bus.ram_data), 0);
    chk({tag, "_clk_start"}, 32'(clk_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_wrap_flag"}, 32'(wrap_flag), 0);
  endtask

  // Monitor: every write and start pulse must match the oldest model expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (post_start) begin
        chk("start_one_cycle", 32'(clk_start), 0);
        chk("busy_after_start", 32'(busy), 0);
        chk("ready_after_start", 32'(bus.pix_ready), 0);
        post_start = 0;
      end else if (clk_start) begin
        if (start_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          start_t s;
          s = start_q.pop_front();
          chk("start_writes_done", 32'(exp_w.size()), 0);
          chk("start_busy", 32'(busy), 1);
          chk("start_wrap_flag", 32'(wrap_flag), 32'(s.wrap));
          // Edges from the one sampling load_req to the one sampling clk_start, inclusive.
          if (s.cont) chk("start_latency", 32'((cyc + 1) - s.edge_no + 1), NPIX + 3);
`ifdef LOADER_CHECKSUM_EN
          chk("start_checksum", 32'(checksum), 32'(s.sum));
`endif
          post_start = 1;
        end
      end
      if (bus.ram_wren) begin
        if (exp_w.size() == 0) begin
          chk("unexpected_write", 32'(bus.ram_wraddress), 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = exp_w.pop_front();
          chk("write_addr", 32'(bus.ram_wraddress), 32'(w.addr));
          chk("write_data", 32'(bus.ram_data), 32'(w.data));
          chk("write_wrap_flag", 32'(wrap_flag), 32'(w.wrap));
          chk("write_busy", 32'(busy), 1);
        end
      end
    end
  end

  // mode: 0 continuous valid, 1 toggling 1/0, 2 random. kind: 0 addr low byte, 1 all 0xFF, 2 random.
  task automatic run_load(input logic [11:0] base, input int mode, input int kind,
                          input int abort_after, input bit inject);
    int          idx;
    int          cycles;
    logic        v;
    logic [7:0]  px;
    logic [12:0] full;
    logic        wrap_s;
    logic [15:0] sum;
    wr_t         w;
    start_t      s;
    idx    = 0;
    cycles = 0;
    wrap_s = 1'b0;
    sum    = '0;
    @(negedge clk);
    load_req  = 1'b1;
    base_addr = base;
    pix_valid_drive(mode == 0, 8'($urandom));
    s.edge_no = cyc + 1;
    s.cont    = (mode == 0);
    @(negedge clk);
    load_req  = 1'b0;
    base_addr = 12'($urandom);
    while (idx < NPIX && cycles < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cycles % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      full = {1'b0, base} + 13'(idx);
      case (kind)
        0:       px = full[7:0];
        1:       px = 8'hFF;
        default: px = 8'($urandom);
      endcase
      if (inject && cycles == 4) begin
        load_req  = 1'b1;
        base_addr = 12'h100;
      end else begin
        load_req = 1'b0;
      end
      pix_valid_drive(v, v ? px : 8'($urandom));
      if (v && bus.pix_ready) begin
        wrap_s = wrap_s | full[12];
        w.addr = full[11:0];
        w.data = px;
        w.wrap = wrap_s;
        exp_w.push_back(w);
        sum = sum + 16'(px);
        idx++;
        if (idx == NPIX) begin
          s.wrap = wrap_s;
          s.sum  = sum;
          start_q.push_back(s);
        end
      end
      @(negedge clk);
      cycles++;
      if (abort_after != 0 && idx == abort_after) break;
    end
    load_req = 1'b0;
    if (abort_after != 0) begin
      pix_valid_drive(1'b0, 8'h00);
      #2 reset = 1'b1;
      #1 chk_all_zero("abort");
      @(negedge clk);
      reset = 1'b0;
      exp_w.delete();
      post_start = 0;
      repeat (8) @(negedge clk);
      chk("abort_no_busy", 32'(busy), 0);
    end else begin
      chk("load_progress", 32'(idx), NPIX);
      pix_valid_drive(1'b1, 8'($urandom));
      for (int k = 0; k < 10 && start_q.size() != 0; k++) @(negedge clk);
      chk("start_seen", 32'(start_q.size()), 0);
      start_q.delete();
      @(negedge clk);
      pix_valid_drive(1'b0, 8'h00);
    end
  endtask

  task automatic pix_valid_drive(input logic v, input logic [7:0] d);
    bus.pix_valid = v;
    bus.pix_data  = d;
  endtask

  initial begin
    reset     = 1'b0;
    load_req  = 1'b0;
    base_addr = '0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    #3 reset = 1'b1;
    #1 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run_load(12'h000, 0, 0, 0, 1'b0);
    run_load(12'h5A0, 1, 2, 0, 1'b0);
    run_load(12'hFF8, 0, 0, 0, 1'b0);
    @(negedge clk);
    chk("wrap_sticky_idle", 32'(wrap_flag), 1);
    run_load(12'h200, 1, 2, 0, 1'b1);
    run_load(12'h300, 0, 2, 5, 1'b0);
    run_load(12'h040, 0, 0, 0, 1'b0);
    run_load(12'h080, 0, 1, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run_load(12'($urandom), $urandom_range(0, 2), 2, 0, 1'b0);
    end
    repeat (4) @(negedge clk);
    chk("final_writes_drained", 32'(exp_w.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
